pf_lanectrl_dly_move_seq: RTL and testbench

Delay-line move sequencer directly upstream of the address/command lane controller. Converts one fabric request ("move TX or RX delay line N taps in a direction", or "reload") into the pause-protected pulse sequence on DELAY_LINE_SEL/LOAD/DIRECTION/MOVE and HS_IO_CLK_PAUSE that the lane controller consumes. Aborts on the lane's out-of-range flag. Runs on the fabric clock feeding the lane controller; HS_IO_CLK_PAUSE is resynchronised downstream.

---
 rtl/pf_lanectrl_dly_move_seq.sv | 215 +++++++++++++++++++++
 tb/tb_pf_lanectrl_dly_move_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_lanectrl_dly_move_seq.sv
// rtl/pf_lanectrl_dly_move_seq.sv - pause-protected delay-line MOVE/LOAD pulse sequencer for the lane controller
// Optional: PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN adds a saturating signed tap position tracker (o_tap_pos).
module pf_lanectrl_dly_move_seq #(
  parameter int PAUSE_SETUP = 2,
  parameter int MOVE_GAP    = 3,
  parameter int PAUSE_HOLD  = 2
) (
  input  logic       i_fab_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_sel,
  input  logic       i_req_load,
  input  logic       i_req_dir,
  input  logic [7:0] i_req_taps,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_done_oor,
  output logic [7:0] o_taps_moved,
  output logic       o_delay_line_sel,
  output logic       o_delay_line_load,
  output logic       o_delay_line_direction,
  output logic       o_delay_line_move,
  output logic       o_hs_io_clk_pause,
`ifdef PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN
  output logic signed [8:0] o_tap_pos,
`endif
  input  logic       i_rx_delay_line_out_of_range,
  input  logic       i_tx_delay_line_out_of_range
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_HOLD  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(PAUSE_SETUP - 1);
  localparam logic [3:0] GAP_LAST   = 4'(MOVE_GAP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(PAUSE_HOLD - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_sel;
  logic       r_dir;
  logic       r_load;
  logic [7:0] r_cnt;
  logic [3:0] r_tmr;
  logic       r_oor;
  logic       r_pulse_d;
  logic [7:0] r_taps_moved;

  logic w_accept;
  logic w_oor_line;
  logic w_oor_hit;
  logic w_zero_req;

  assign w_accept   = i_req_valid && (r_state == S_IDLE);
  assign w_zero_req = !i_req_load && (i_req_taps == 8'd0);
  assign w_oor_line = r_sel ? i_tx_delay_line_out_of_range : i_rx_delay_line_out_of_range;
  // With MOVE_GAP=0 the cycle after a pulse is itself a pulse, so r_pulse_d covers that sample point.
  assign w_oor_hit  = w_oor_line && ((r_state == S_GAP) || (r_state == S_HOLD) ||
                                     ((r_state == S_PULSE) && r_pulse_d));

  always_ff @(posedge i_fab_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_zero_req ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_tmr == 4'd0) begin
          w_next = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_load || (r_cnt == 8'd1) || w_oor_hit) begin
          w_next = S_HOLD;
        end else if (MOVE_GAP == 0) begin
          w_next = S_PULSE;
        end else begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_oor_hit) begin
          w_next = S_HOLD;
        end else if (r_tmr == 4'd0) begin
          w_next = S_PULSE;
        end
      end
      S_HOLD: begin
        if (r_tmr == 4'd0) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready            = 1'b0;
    o_busy                 = 1'b0;
    o_done                 = 1'b0;
    o_done_oor             = 1'b0;
    o_hs_io_clk_pause      = 1'b0;
    o_delay_line_sel       = 1'b0;
    o_delay_line_direction = 1'b0;
    o_delay_line_move      = 1'b0;
    o_delay_line_load      = 1'b0;
    case (r_state)
      S_IDLE: o_req_ready = 1'b1;
      S_SETUP, S_GAP, S_HOLD: begin
        o_busy                 = 1'b1;
        o_hs_io_clk_pause      = 1'b1;
        o_delay_line_sel       = r_sel;
        o_delay_line_direction = r_dir;
      end
      S_PULSE: begin
        o_busy                 = 1'b1;
        o_hs_io_clk_pause      = 1'b1;
        o_delay_line_sel       = r_sel;
        o_delay_line_direction = r_dir;
        o_delay_line_move      = !r_load;
        o_delay_line_load      = r_load;
      end
      S_FIN: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        o_done_oor = r_oor;
      end
      default: o_req_ready = 1'b0;
    endcase
  end

  assign o_taps_moved = r_taps_moved;

  always_ff @(posedge i_fab_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel        <= 1'b0;
      r_dir        <= 1'b0;
      r_load       <= 1'b0;
      r_cnt        <= 8'd0;
      r_tmr        <= 4'd0;
      r_oor        <= 1'b0;
      r_pulse_d    <= 1'b0;
      r_taps_moved <= 8'd0;
    end else begin
      r_pulse_d <= (r_state == S_PULSE);
      if (w_accept) begin
        r_sel        <= i_req_sel;
        r_dir        <= i_req_dir;
        r_load       <= i_req_load;
        r_cnt        <= i_req_taps;
        r_oor        <= 1'b0;
        r_taps_moved <= 8'd0;
      end
      if ((r_state == S_PULSE) && !r_load) begin
        r_cnt        <= r_cnt - 8'd1;
        r_taps_moved <= r_taps_moved + 8'd1;
      end
      if (w_oor_hit) begin
        r_oor <= 1'b1;
      end
      if (w_next != r_state) begin
        case (w_next)
          S_SETUP: r_tmr <= SETUP_LAST;
          S_GAP:   r_tmr <= GAP_LAST;
          S_HOLD:  r_tmr <= HOLD_LAST;
          default: r_tmr <= 4'd0;
        endcase
      end else if (r_tmr != 4'd0) begin
        r_tmr <= r_tmr - 4'd1;
      end
    end
  end

`ifdef PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN
  localparam logic signed [8:0] TAP_MAX = 9'sh0FF;
  localparam logic signed [8:0] TAP_MIN = 9'sh100;

  logic signed [8:0] r_tap_pos;

  always_ff @(posedge i_fab_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tap_pos <= 9'sd0;
    end else if ((r_state == S_PULSE) && !r_load) begin
      if (r_dir && (r_tap_pos != TAP_MAX)) begin
        r_tap_pos <= r_tap_pos + 9'sd1;
      end else if (!r_dir && (r_tap_pos != TAP_MIN)) begin
        r_tap_pos <= r_tap_pos - 9'sd1;
      end
    end else if ((r_state == S_FIN) && r_load) begin
      r_tap_pos <= 9'sd0;
    end
  end

  assign o_tap_pos = r_tap_pos;
`endif

endmodule

// File: tb/tb_pf_lanectrl_dly_move_seq.sv
// tb/tb_pf_lanectrl_dly_move_seq.sv - self-checking bench for pf_lanectrl_dly_move_seq against a schedule model
module tb_pf_lanectrl_dly_move_seq;

  localparam int PS    = 2;
  localparam int MG    = 3;
  localparam int PH    = 2;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_sel, req_load, req_dir;
  logic [7:0] req_taps;
  logic       busy, done, done_oor;
  logic [7:0] taps_moved;
  logic       dl_sel, dl_load, dl_dir, dl_move, pause;
  logic       rx_oor, tx_oor;
`ifdef PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN
  logic signed [8:0] tap_pos;
`endif

  int checks = 0;
  int errors = 0;

  bit exp_mv [0:255];
  bit exp_ld [0:255];

  always #5 clk = ~clk;

  pf_lanectrl_dly_move_seq #(.PAUSE_SETUP(PS), .MOVE_GAP(MG), .PAUSE_HOLD(PH)) dut (
    .i_fab_clk                    (clk),
    .i_reset                      (rst),
    .i_req_valid                  (req_valid),
    .o_req_ready                  (req_ready),
    .i_req_sel                    (req_sel),
    .i_req_load                   (req_load),
    .i_req_dir                    (req_dir),
    .i_req_taps                   (req_taps),
    .o_busy                       (busy),
    .o_done                       (done),
    .o_done_oor                   (done_oor),
    .o_taps_moved                 (taps_moved),
    .o_delay_line_sel             (dl_sel),
    .o_delay_line_load            (dl_load),
    .o_delay_line_direction       (dl_dir),
    .o_delay_line_move            (dl_move),
    .o_hs_io_clk_pause            (pause),
`ifdef PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN
    .o_tap_pos                    (tap_pos),
`endif
    .i_rx_delay_line_out_of_range (rx_oor),
    .i_tx_delay_line_out_of_range (tx_oor)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected schedule from the request rules: pulse cycles, hold start, done cycle, OOR outcome.
  task automatic build_model(input bit load, input int taps, input int oor_at,
                             output int done_c, output int npulse, output bit oorf);
    int t;
    int hold;
    bit stop;
    for (int i = 0; i < 256; i++) begin
      exp_mv[i] = 1'b0;
      exp_ld[i] = 1'b0;
    end
    oorf   = 1'b0;
    npulse = 0;
    hold   = 0;
    if (!load && taps == 0) begin
      done_c = 1;
      return;
    end
    t = 1 + PS;
    if (load) begin
      exp_ld[t] = 1'b1;
      hold = t + 1;
    end else begin
      stop = 1'b0;
      while (!stop) begin
        exp_mv[t] = 1'b1;
        npulse++;
        if (npulse == taps) begin
          hold = t + 1;
          stop = 1'b1;
        end else begin
          for (int g = 1; g <= MG && !stop; g++) begin
            if (t + g >= oor_at) begin
              oorf = 1'b1;
              hold = t + g + 1;
              stop = 1'b1;
            end
          end
          if (!stop) t += MG + 1;
        end
      end
    end
    for (int h = hold; h < hold + PH; h++) begin
      if (h >= oor_at) oorf = 1'b1;
    end
    done_c = hold + PH;
  endtask

  // Called in an idle cycle (cycle 0); returns in the idle cycle after DONE.
  task automatic run_req(input bit sel, input bit dir, input bit load, input int taps,
                         input int oor_at, output int act_done, output int act_moves);
    int  edone, enp;
    bit  eoor;
    bit  epause;
    build_model(load, taps, oor_at, edone, enp, eoor);
    act_done = -1;
    chk("ready_c0", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_load  = load;
    req_taps  = 8'(taps);
    for (int c = 1; c <= edone + 1; c++) begin
      @(posedge clk);
      #1;
      if (sel) begin
        tx_oor = (c >= oor_at);
        rx_oor = 1'($urandom);
      end else begin
        rx_oor = (c >= oor_at);
        tx_oor = 1'($urandom);
      end
      if (c <= edone) begin
        epause = (c < edone) && (load || taps != 0);
        if (done === 1'b1 && act_done < 0) act_done = c;
        chk($sformatf("pause_c%0d", c), 32'(pause), 32'(epause));
        chk($sformatf("move_c%0d", c), 32'(dl_move), 32'(exp_mv[c]));
        chk($sformatf("load_c%0d", c), 32'(dl_load), 32'(exp_ld[c]));
        chk($sformatf("done_c%0d", c), 32'(done), 32'(c == edone));
        chk($sformatf("oor_c%0d", c), 32'(done_oor), 32'((c == edone) && eoor));
        chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
        chk($sformatf("sel_c%0d", c), 32'(dl_sel), 32'(epause && sel));
        chk($sformatf("dir_c%0d", c), 32'(dl_dir), 32'(epause && dir));
        if (c == edone) chk("taps_moved_done", 32'(taps_moved), 32'(enp));
      end else begin
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("taps_moved_held", 32'(taps_moved), 32'(enp));
      end
      if (c < edone) begin
        req_valid = 1'($urandom);
        req_sel   = 1'($urandom);
        req_dir   = 1'($urandom);
        req_load  = 1'($urandom);
        req_taps  = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    act_moves = int'(taps_moved);
    rx_oor = 1'b0;
    tx_oor = 1'b0;
  endtask

  initial begin
    int ad, am;
    rst = 1'b0;
    req_valid = 1'b0; req_sel = 1'b0; req_load = 1'b0; req_dir = 1'b0; req_taps = 8'd0;
    rx_oor = 1'b0; tx_oor = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_taps_moved", 32'(taps_moved), 32'd0);
`ifdef PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN
    chk("rst_tap_pos", 32'({tap_pos}), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_req(1'b1, 1'b1, 1'b0, 3, NEVER, ad, am);
    chk("basic_done_cycle", 32'(ad), 32'd14);
    chk("basic_moves", 32'(am), 32'd3);

    run_req(1'b0, 1'b1, 1'b1, 200, NEVER, ad, am);
    chk("load_done_cycle", 32'(ad), 32'd6);
    chk("load_moves", 32'(am), 32'd0);

    run_req(1'b0, 1'b0, 1'b0, 10, 8, ad, am);
    chk("oor_done_cycle", 32'(ad), 32'd11);
    chk("oor_moves", 32'(am), 32'd2);

    run_req(1'b1, 1'b0, 1'b0, 0, NEVER, ad, am);
    chk("zero_done_cycle", 32'(ad), 32'd1);
    chk("zero_moves", 32'(am), 32'd0);

    run_req(1'b1, 1'b1, 1'b0, 5, NEVER, ad, am);
    chk("busy_ignore_moves", 32'(am), 32'd5);

    // Reset mid-sequence: first in a gap cycle, then on a MOVE pulse.
    req_valid = 1'b1; req_sel = 1'b1; req_dir = 1'b1; req_load = 1'b0; req_taps = 8'd4;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("prerst_pause", 32'(pause), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pause", 32'(pause), 32'd0);
    chk("midrst_move", 32'(dl_move), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("postrst_done", 32'(done), 32'd0);
      chk("postrst_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b1; req_taps = 8'd4;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("prerst_move", 32'(dl_move), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_move2", 32'(dl_move), 32'd0);
    chk("midrst_pause2", 32'(pause), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst2_ready", 32'(req_ready), 32'd1);
    chk("postrst2_done", 32'(done), 32'd0);

    for (int n = 0; n < 40; n++) begin
      run_req(1'($urandom), 1'($urandom), ($urandom % 5) == 0, int'($urandom % 7),
              (($urandom % 3) == 0) ? int'($urandom_range(1, 25)) : NEVER, ad, am);
    end

`ifdef PF_LANECTRL_DLY_MOVE_SEQ_TAP_TRACK_EN
    run_req(1'b0, 1'b0, 1'b1, 0, NEVER, ad, am);
    chk("track_clear", 32'({tap_pos}), 32'd0);
    run_req(1'b1, 1'b1, 1'b0, 5, NEVER, ad, am);
    chk("track_plus5", 32'({tap_pos}), 32'd5);
    run_req(1'b1, 1'b0, 1'b0, 3, NEVER, ad, am);
    chk("track_minus3", 32'({tap_pos}), 32'd2);
    run_req(1'b1, 1'b0, 1'b1, 9, NEVER, ad, am);
    chk("track_load", 32'({tap_pos}), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
